// File: rtl/count_sched_pkg.sv
// Shared types and constants for the two-requester run-length counter scheduler.
// Holds the FSM state encoding, the default run-length width and the requester channel indices.
package count_sched_pkg;

    localparam int LEN_W_DEF = 16;

    localparam logic REQ_CH0 = 1'b0;
    localparam logic REQ_CH1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot grant vector for a requester index.
    function automatic logic [1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin arbiter.
// On a tie the requester that was not served last wins.
module rr_arb2
    import count_sched_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = onehot_of(REQ_CH0);
            2'b10:   o_gnt = onehot_of(REQ_CH1);
            2'b11:   o_gnt = onehot_of(~i_last);
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/count_sched.sv
// Scheduler that grants a shared dual-channel counter to one of two requesters
// for a run of Len enabled cycles, followed by a single Done cycle.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [LEN_W-1:0] Len0,
    input  logic             Req1,
    input  logic [LEN_W-1:0] Len1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Slt,
    output logic             En,
    output logic             Busy,
    output logic             Done,
    output state_t           o_dbg_state
);

    state_t           r_state;
    logic             r_owner;
    logic             r_last;
    logic [LEN_W-1:0] r_rem;

    state_t           w_next_state;
    logic             w_next_owner;
    logic             w_next_last;
    logic [LEN_W-1:0] w_next_rem;
    logic [1:0]       w_gnt;
    logic [LEN_W-1:0] w_grant_len;

    rr_arb2 u_arb (
        .i_req  ({Req1, Req0}),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    assign w_grant_len = w_gnt[1] ? Len1 : Len0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_owner <= REQ_CH0;
            r_last  <= REQ_CH1;
            r_rem   <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_last  <= w_next_last;
            r_rem   <= w_next_rem;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_last  = r_last;
        w_next_rem   = r_rem;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_next_owner = w_gnt[1];
                    w_next_rem   = w_grant_len;
                    w_next_state = (w_grant_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                w_next_rem = r_rem - 1'b1;
                // r_rem is never 0 here; the <= keeps a corrupted count from wrapping.
                if (r_rem <= {{(LEN_W-1){1'b0}}, 1'b1}) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_last  = r_owner;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // All outputs are pure decodes of registered state.
    assign Busy        = (r_state != IDLE);
    assign En          = (r_state == RUN);
    assign Done        = (r_state == DONE);
    assign Gnt0        = Busy && (r_owner == REQ_CH0);
    assign Gnt1        = Busy && (r_owner == REQ_CH1);
    assign Slt         = r_owner;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: single runs, zero and maximum length, tie alternation
// and reset in the middle of a run, with a Done-time scoreboard of owner and En count.
module tb_count_sched;
    import count_sched_pkg::*;

    localparam int LW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Req0;
    logic          Req1;
    logic [LW-1:0] Len0;
    logic [LW-1:0] Len1;
    logic          Gnt0;
    logic          Gnt1;
    logic          Slt;
    logic          En;
    logic          Busy;
    logic          Done;
    state_t        o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry is {owner, run length}, checked when its Done pulse appears.
    logic [LW:0] exp_q[$];
    logic [LW:0] sb_e;
    int          en_cnt    = 0;
    bit          both_seen = 1'b0;

    count_sched #(.LEN_W(LW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req0        (Req0),
        .Len0        (Len0),
        .Req1        (Req1),
        .Len1        (Len1),
        .Gnt0        (Gnt0),
        .Gnt1        (Gnt1),
        .Slt         (Slt),
        .En          (En),
        .Busy        (Busy),
        .Done        (Done),
        .o_dbg_state (o_dbg_state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (Gnt0 && Gnt1) both_seen = 1'b1;
        if (Reset) begin
            en_cnt = 0;
        end else begin
            if (En) en_cnt++;
            if (Done) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 1, 0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_owner", Slt, sb_e[LW]);
                    check("sb_len", en_cnt, sb_e[LW-1:0]);
                end
                en_cnt = 0;
            end
        end
    end

    task automatic run_one(input logic ch, input logic [LW-1:0] len);
        int seen = 0;
        bit bad  = 1'b0;
        if (ch) begin
            Req1 = 1'b1;
            Len1 = len;
        end else begin
            Req0 = 1'b1;
            Len0 = len;
        end
        exp_q.push_back({ch, len});
        step();
        Req0 = 1'b0;
        Req1 = 1'b0;
        Len0 = LW'($urandom_range(0, 15));
        Len1 = LW'($urandom_range(0, 15));
        check("gnt", {Gnt1, Gnt0}, ch ? 2 : 1);
        check("busy", Busy, 1);
        for (int i = 0; i < int'(len); i++) begin
            if (En) seen++;
            if (Slt !== ch || {Gnt1, Gnt0} !== onehot_of(ch)) bad = 1'b1;
            step();
        end
        check("done", Done, 1);
        check("en_at_done", En, 0);
        check("gnt_at_done", {Gnt1, Gnt0}, ch ? 2 : 1);
        check("en_cycles", seen, len);
        check("run_stable", bad, 0);
        step();
        check("idle_state", o_dbg_state, IDLE);
        check("idle_busy", Busy, 0);
        check("idle_done", Done, 0);
        check("idle_gnt", {Gnt1, Gnt0}, 0);
        check("idle_slt", Slt, ch);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  grants;
        bit  prev_g;
        bit  prev_done;
        int  gap_bad;
        bit  finished;

        Reset = 1'b1;
        Req0  = 1'b0;
        Req1  = 1'b0;
        Len0  = '0;
        Len1  = '0;
        step();
        step();
        check("rst_gnt", {Gnt1, Gnt0}, 0);
        check("rst_en", En, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_slt", Slt, 0);
        check("rst_state", o_dbg_state, IDLE);
        Reset = 1'b0;
        step();

        run_one(REQ_CH0, 4'd5);
        run_one(REQ_CH1, 4'd8);
        run_one(REQ_CH0, 4'd0);
        run_one(REQ_CH1, 4'd15);

        // Tie held across reset release: grants must alternate 0,1,0,1.
        Reset = 1'b1;
        Req0  = 1'b1;
        Req1  = 1'b1;
        Len0  = 4'd3;
        Len1  = 4'd3;
        step();
        check("rst_prio_gnt", {Gnt1, Gnt0}, 0);
        check("rst_prio_busy", Busy, 0);
        exp_q.push_back({REQ_CH0, 4'd3});
        exp_q.push_back({REQ_CH1, 4'd3});
        exp_q.push_back({REQ_CH0, 4'd3});
        exp_q.push_back({REQ_CH1, 4'd3});
        Reset     = 1'b0;
        grants    = 0;
        prev_g    = 1'b0;
        prev_done = 1'b0;
        gap_bad   = 0;
        finished  = 1'b0;
        for (int c = 0; c < 60 && !finished; c++) begin
            step();
            if ((Gnt0 || Gnt1) && !prev_g) begin
                check("tie_order", Gnt1, grants % 2);
                grants++;
                if (grants == 4) begin
                    Req0 = 1'b0;
                    Req1 = 1'b0;
                end
            end
            if (prev_done && Busy) gap_bad++;
            if (Done && grants == 4) finished = 1'b1;
            prev_g    = Gnt0 || Gnt1;
            prev_done = Done;
        end
        check("tie_grants", grants, 4);
        check("tie_finished", finished, 1);
        check("tie_gap", gap_bad, 0);
        step();
        check("tie_idle", Busy, 0);

        // Reset in the third En cycle of a 10-cycle run.
        Req0 = 1'b1;
        Len0 = 4'd10;
        step();
        Req0 = 1'b0;
        step();
        step();
        check("pre_rst_en", En, 1);
        Reset = 1'b1;
        Req0  = 1'b1;
        Req1  = 1'b1;
        Len0  = 4'd2;
        Len1  = 4'd2;
        step();
        check("mid_rst_en", En, 0);
        check("mid_rst_state", o_dbg_state, IDLE);
        check("mid_rst_done", Done, 0);
        check("mid_rst_gnt", {Gnt1, Gnt0}, 0);
        Reset = 1'b0;
        exp_q.push_back({REQ_CH0, 4'd2});
        step();
        check("post_rst_tie", {Gnt1, Gnt0}, 1);
        Req0 = 1'b0;
        Req1 = 1'b0;
        step();
        step();
        check("post_rst_done", Done, 1);
        step();
        check("post_rst_idle", Busy, 0);

        check("gnt_excl", both_seen, 0);
        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
